// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer driving an external 1-bit full-adder cell.
// Operands are consumed LSB first; the ripple carry is held in a register.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] Operand_A,
    input  logic [WIDTH-1:0] Operand_B,
    input  logic             Carry_in,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry_out,
    output logic             FA_A,
    output logic             FA_B,
    output logic             FA_Carry_in,
    input  logic             FA_Sum,
    input  logic             FA_Carry_out
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] s_sh;
    logic             c_reg;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] s_nxt;
    logic             running;
    logic             last;

    assign running     = (state == RUN);
    assign last        = (cnt == CW'(WIDTH - 1));
    assign s_nxt       = {FA_Sum, s_sh};

    assign FA_A        = running & a_sh[0];
    assign FA_B        = running & b_sh[0];
    assign FA_Carry_in = running & c_reg;

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state     <= IDLE;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Sum       <= '0;
            Carry_out <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            s_sh      <= '0;
            c_reg     <= 1'b0;
            cnt       <= '0;
        end else begin
            Done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        a_sh  <= Operand_A;
                        b_sh  <= Operand_B;
                        c_reg <= Carry_in;
                        cnt   <= '0;
                        Busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    s_sh  <= s_nxt[WIDTH-1:1];
                    c_reg <= FA_Carry_out;
                    cnt   <= cnt + 1'b1;
                    // Final bit: the cell's outputs complete the result directly
                    if (last) begin
                        Sum       <= s_nxt;
                        Carry_out <= FA_Carry_out;
                        Busy      <= 1'b0;
                        Done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl with a behavioural full-adder cell and
// an arithmetic reference model checked on every cycle.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         co;
    logic         fa_a;
    logic         fa_b;
    logic         fa_cin;
    logic         fa_s;
    logic         fa_co;

    int n_cmp = 0;
    int n_bad = 0;

    // Team full-adder cell
    assign fa_s  = fa_a ^ fa_b ^ fa_cin;
    assign fa_co = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .Clock       (clk),
        .Reset_n     (rst_n),
        .Start       (start),
        .Operand_A   (op_a),
        .Operand_B   (op_b),
        .Carry_in    (cin),
        .Busy        (busy),
        .Done        (done),
        .Sum         (sum),
        .Carry_out   (co),
        .FA_A        (fa_a),
        .FA_B        (fa_b),
        .FA_Carry_in (fa_cin),
        .FA_Sum      (fa_s),
        .FA_Carry_out(fa_co)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: remaining bit-edges plus the exact integer sum
    int           m_left = 0;
    bit           m_done = 1'b0;
    int           m_sum = 0;
    int           m_co = 0;
    int           pa = 0;
    int           pb = 0;
    int           pc = 0;
    bit           chk_en = 1'b0;

    always @(posedge clk) begin
        int tot;
        if (!rst_n) begin
            m_left = 0;
            m_done = 1'b0;
            m_sum  = 0;
            m_co   = 0;
        end else if (m_left > 0) begin
            m_left--;
            m_done = 1'b0;
            if (m_left == 0) begin
                tot    = pa + pb + pc;
                m_sum  = tot & 'hFF;
                m_co   = (tot >> W) & 1;
                m_done = 1'b1;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                pa     = int'(op_a);
                pb     = int'(op_b);
                pc     = int'(cin);
                m_left = W;
            end
        end
    end

    always @(negedge clk) begin
        int i;
        int mask;
        int e_a;
        int e_b;
        int e_c;
        if (chk_en) begin
            e_a = 0;
            e_b = 0;
            e_c = 0;
            if (m_left > 0) begin
                i    = W - m_left;
                mask = (1 << i) - 1;
                e_a  = (pa >> i) & 1;
                e_b  = (pb >> i) & 1;
                e_c  = (((pa & mask) + (pb & mask) + pc) >> i) & 1;
            end
            check("busy", int'(busy), int'(m_left > 0));
            check("done", int'(done), int'(m_done));
            check("sum", int'(sum), m_sum);
            check("carry_out", int'(co), m_co);
            check("fa_a", int'(fa_a), e_a);
            check("fa_b", int'(fa_b), e_b);
            check("fa_cin", int'(fa_cin), e_c);
        end
    end

    task automatic go(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic c);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        cin   = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int bcyc);
        bit got;
        got  = 1'b0;
        cyc  = 0;
        bcyc = 0;
        for (int k = 0; k < 30 && !got; k++) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy) bcyc++;
                @(negedge clk);
                cyc++;
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no Done expected Done within 30 cycles");
        end
    endtask

    initial begin
        int cyc;
        int bcyc;
        int dn;

        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_sum", int'(sum), 0);
        check("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: 0x5A + 0x33
        go(8'h5A, 8'h33, 1'b0);
        wait_done(cyc, bcyc);
        check("t1_busy_cycles", bcyc, 8);
        check("t1_sum", int'(sum), 'h8D);
        check("t1_co", int'(co), 0);

        // 2: full carry ripple
        go(8'hFF, 8'h01, 1'b0);
        wait_done(cyc, bcyc);
        check("t2_sum", int'(sum), 'h00);
        check("t2_co", int'(co), 1);

        // 3: max operands with carry-in, then all zero
        go(8'hFF, 8'hFF, 1'b1);
        wait_done(cyc, bcyc);
        check("t3a_sum", int'(sum), 'hFF);
        check("t3a_co", int'(co), 1);
        go(8'h00, 8'h00, 1'b0);
        wait_done(cyc, bcyc);
        check("t3b_sum", int'(sum), 'h00);
        check("t3b_co", int'(co), 0);

        // 4: Start during RUN is ignored
        go(8'h5A, 8'h33, 1'b0);
        @(negedge clk);
        op_a  = 8'h11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op_a  = 8'h00;
        wait_done(cyc, bcyc);
        check("t4_sum", int'(sum), 'h8D);
        dn = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("t4_extra_done", dn, 0);

        // 5: reset on the 4th RUN edge aborts
        go(8'h5A, 8'h33, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t5_busy", int'(busy), 0);
        check("t5_sum", int'(sum), 0);
        check("t5_co", int'(co), 0);
        dn = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("t5_no_done", dn, 0);
        go(8'h5A, 8'h33, 1'b0);
        wait_done(cyc, bcyc);
        check("t5_fresh_sum", int'(sum), 'h8D);

        // 6: Start held through DONE gives back-to-back adds
        @(negedge clk);
        op_a  = 8'h5A;
        op_b  = 8'h33;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        op_a = 8'h01;
        op_b = 8'h02;
        wait_done(cyc, bcyc);
        check("t6_first_sum", int'(sum), 'h8D);
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bcyc);
        check("t6_gap", cyc + 1, 9);
        check("t6_second_sum", int'(sum), 'h03);
        check("t6_second_co", int'(co), 0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
